// File: rtl/snn_pkg.sv
// Shared constants and types for the ROC-to-SNN AER transmit path.
// Holds link widths, the event-type prefix and the transmit FSM states.
package snn_pkg;

    localparam int INDEX_BITS  = 10;
    localparam int AER_WIDTH   = 12;
    localparam int PREFIX_BITS = AER_WIDTH - INDEX_BITS;

    // Event-type field placed above the pixel index on AERIN_ADDR
    localparam logic [PREFIX_BITS-1:0] EVT_PIXEL  = 2'b00;
    localparam logic [PREFIX_BITS-1:0] EVT_PREFIX = EVT_PIXEL;

    localparam int IMAGE_SIZE_DEF  = 784;
    localparam int ACK_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE,
        REQ_UP,
        WAIT_ACK_H,
        WAIT_ACK_L
    } aer_tx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset.
// Ports: clk, rst, d (async input), q (synchronized output).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/roc_aer_tx.sv
// Sends each sorted pixel index from the ROC encoder as one 4-phase
// REQ/ACK AER event, counts delivered spikes per image, flags ACK timeouts.
// Ports: CLK, RST (sync, active high), NEW_IMAGE, NEXT_INDEX,
//   FOUND_NEXT_INDEX, AERIN_CTRL_BUSY, AERIN_ADDR, AERIN_REQ, AERIN_ACK,
//   SPIKE_CNT, IMAGE_SENT, ERR_TIMEOUT.
module roc_aer_tx
    import snn_pkg::*;
#(
    parameter int IMAGE_SIZE  = IMAGE_SIZE_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    localparam int CNT_W      = $clog2(IMAGE_SIZE + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  NEW_IMAGE,
    input  logic [INDEX_BITS-1:0] NEXT_INDEX,
    input  logic                  FOUND_NEXT_INDEX,
    output logic                  AERIN_CTRL_BUSY,
    output logic [AER_WIDTH-1:0]  AERIN_ADDR,
    output logic                  AERIN_REQ,
    input  logic                  AERIN_ACK,
    output logic [CNT_W-1:0]      SPIKE_CNT,
    output logic                  IMAGE_SENT,
    output logic                  ERR_TIMEOUT
);

    localparam int TO_W =
        (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IMAGE_SIZE);

    aer_tx_state_t         state, state_n;
    logic                  busy_q, busy_n;
    logic                  req_q, req_n;
    logic [AER_WIDTH-1:0]  addr_q, addr_n;
    logic                  err_q, err_n;
    logic                  guard_q, guard_n;
    logic                  done;
    logic                  expired;
    logic                  ack_s;
    logic [TO_W-1:0]       to_cnt;
    logic [CNT_W-1:0]      cnt_q;
    logic                  sent_q;

    sync_2ff #(
        .WIDTH(1)
    ) u_ack_sync (
        .clk(CLK),
        .rst(RST),
        .d  (AERIN_ACK),
        .q  (ack_s)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            guard_q <= 1'b0;
        end else begin
            state   <= state_n;
            busy_q  <= busy_n;
            req_q   <= req_n;
            addr_q  <= addr_n;
            err_q   <= err_n;
            guard_q <= guard_n;
        end
    end

    always_comb begin
        state_n = state;
        busy_n  = busy_q;
        req_n   = req_q;
        addr_n  = addr_q;
        err_n   = err_q;
        guard_n = 1'b0;
        done    = 1'b0;
        expired = (ACK_TIMEOUT != 0) && (to_cnt == TO_LAST);
        unique case (state)
            IDLE: begin
                // First IDLE cycle after a transfer is skipped so a
                // FOUND still held from the last index is not resent.
                // A stale high ACK also blocks acceptance.
                if (!guard_q && FOUND_NEXT_INDEX && !ack_s) begin
                    addr_n  = {EVT_PREFIX, NEXT_INDEX};
                    busy_n  = 1'b1;
                    state_n = REQ_UP;
                end
            end
            REQ_UP: begin
                req_n   = 1'b1;
                state_n = WAIT_ACK_H;
            end
            WAIT_ACK_H: begin
                if (ack_s) begin
                    req_n   = 1'b0;
                    state_n = WAIT_ACK_L;
                end else if (expired) begin
                    err_n   = 1'b1;
                    req_n   = 1'b0;
                    busy_n  = 1'b0;
                    guard_n = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_ACK_L: begin
                if (!ack_s) begin
                    done    = 1'b1;
                    busy_n  = 1'b0;
                    guard_n = 1'b1;
                    state_n = IDLE;
                end else if (expired) begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    guard_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // Restarts on every state change, so each ACK edge gets a full window
    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt <= '0;
        end else if (ACK_TIMEOUT == 0 || state_n != state) begin
            to_cnt <= '0;
        end else if (state == WAIT_ACK_H || state == WAIT_ACK_L) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    // A full count is shown for one cycle, then wraps with IMAGE_SENT.
    // NEW_IMAGE beats a completion landing in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            sent_q <= 1'b0;
        end else begin
            sent_q <= (cnt_q == CNT_MAX);
            if (NEW_IMAGE || cnt_q == CNT_MAX) begin
                cnt_q <= '0;
            end else if (done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign AERIN_CTRL_BUSY = busy_q;
    assign AERIN_REQ       = req_q;
    assign AERIN_ADDR      = addr_q;
    assign ERR_TIMEOUT     = err_q;
    assign SPIKE_CNT       = cnt_q;
    assign IMAGE_SENT      = sent_q;

endmodule

// File: tb/tb_roc_aer_tx.sv
// Directed self-checking bench for roc_aer_tx.
// Uses IMAGE_SIZE=7 and ACK_TIMEOUT=8 with a delayed-ACK core model.
module tb_roc_aer_tx;

    logic        CLK;
    logic        RST;
    logic        NEW_IMAGE;
    logic [9:0]  NEXT_INDEX;
    logic        FOUND_NEXT_INDEX;
    logic        AERIN_CTRL_BUSY;
    logic [11:0] AERIN_ADDR;
    logic        AERIN_REQ;
    logic        AERIN_ACK;
    logic [2:0]  SPIKE_CNT;
    logic        IMAGE_SENT;
    logic        ERR_TIMEOUT;

    int tests = 0;
    int fails = 0;

    logic [11:0] addr_q[$];
    int          req_count  = 0;
    int          sent_count = 0;

    logic ack_auto   = 1'b0;
    int   dly        = 0;
    bit   ack_manual = 1'b0;
    logic ack_man    = 1'b0;

    logic [9:0] idx_tab [7] = '{10'd6, 10'd2, 10'd0, 10'd5,
                                10'd1, 10'd3, 10'd4};

    roc_aer_tx #(
        .IMAGE_SIZE (7),
        .ACK_TIMEOUT(8)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .NEW_IMAGE       (NEW_IMAGE),
        .NEXT_INDEX      (NEXT_INDEX),
        .FOUND_NEXT_INDEX(FOUND_NEXT_INDEX),
        .AERIN_CTRL_BUSY (AERIN_CTRL_BUSY),
        .AERIN_ADDR      (AERIN_ADDR),
        .AERIN_REQ       (AERIN_REQ),
        .AERIN_ACK       (AERIN_ACK),
        .SPIKE_CNT       (SPIKE_CNT),
        .IMAGE_SENT      (IMAGE_SENT),
        .ERR_TIMEOUT     (ERR_TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Core model: ACK follows REQ on the third sample after a change
    always @(negedge CLK) begin
        if (ack_manual) begin
            ack_auto <= 1'b0;
            dly      <= 0;
        end else if (AERIN_REQ != ack_auto) begin
            if (dly == 2) begin
                ack_auto <= AERIN_REQ;
                dly      <= 0;
            end else begin
                dly <= dly + 1;
            end
        end else begin
            dly <= 0;
        end
    end

    assign AERIN_ACK = ack_manual ? ack_man : ack_auto;

    always @(posedge AERIN_REQ) begin
        addr_q.push_back(AERIN_ADDR);
        req_count <= req_count + 1;
    end

    always @(posedge IMAGE_SENT) begin
        sent_count <= sent_count + 1;
    end

    task automatic wait_busy_low(input string tag);
        int n;
        n = 0;
        while (AERIN_CTRL_BUSY === 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        if (AERIN_CTRL_BUSY !== 1'b0) begin
            fails++;
            $display("FAIL %s_busy_fall: got %b want 0",
                     tag, AERIN_CTRL_BUSY);
        end
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        int n;
        n = 0;
        while (AERIN_REQ !== lvl && n < 40) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        if (AERIN_REQ !== lvl) begin
            fails++;
            $display("FAIL %s_req_wait: got %b want %b",
                     tag, AERIN_REQ, lvl);
        end
    endtask

    task automatic send_event(input logic [9:0] idx, input int hold);
        @(negedge CLK);
        NEXT_INDEX       = idx;
        FOUND_NEXT_INDEX = 1'b1;
        repeat (hold) @(negedge CLK);
        FOUND_NEXT_INDEX = 1'b0;
        wait_busy_low("send");
    endtask

    task automatic pulse_new_image();
        @(negedge CLK);
        NEW_IMAGE = 1'b1;
        @(negedge CLK);
        NEW_IMAGE = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        bad              = 0;
        RST              = 1'b1;
        NEW_IMAGE        = 1'b0;
        NEXT_INDEX       = 10'd3;
        FOUND_NEXT_INDEX = 1'b1;
        repeat (25) begin
            @(negedge CLK);
            if (AERIN_REQ !== 1'b0 || AERIN_CTRL_BUSY !== 1'b0)
                bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_hold: %0d bad cycles want 0", bad);
        end
        tests++;
        if ({AERIN_CTRL_BUSY, AERIN_REQ, AERIN_ADDR, SPIKE_CNT,
             IMAGE_SENT, ERR_TIMEOUT} !== 19'd0) begin
            fails++;
            $display("FAIL reset_vals: busy=%b req=%b addr=%h cnt=%0d sent=%b err=%b want all 0",
                     AERIN_CTRL_BUSY, AERIN_REQ, AERIN_ADDR,
                     SPIKE_CNT, IMAGE_SENT, ERR_TIMEOUT);
        end
        RST = 1'b0;
        @(negedge CLK);
        tests++;
        if (AERIN_REQ !== 1'b0 || AERIN_CTRL_BUSY !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: req=%b busy=%b want 0 1",
                     AERIN_REQ, AERIN_CTRL_BUSY);
        end
        FOUND_NEXT_INDEX = 1'b0;
        wait_busy_low("reset");
        tests++;
        if (SPIKE_CNT !== 3'd1) begin
            fails++;
            $display("FAIL reset_first_cnt: got %0d want 1", SPIKE_CNT);
        end
        pulse_new_image();
        tests++;
        if (SPIKE_CNT !== 3'd0) begin
            fails++;
            $display("FAIL new_image_clear: got %0d want 0", SPIKE_CNT);
        end
    endtask

    task automatic test_single_event();
        int r0;
        r0 = req_count;
        @(negedge CLK);
        NEXT_INDEX       = 10'd37;
        FOUND_NEXT_INDEX = 1'b1;
        @(negedge CLK);
        FOUND_NEXT_INDEX = 1'b0;
        tests++;
        if (AERIN_CTRL_BUSY !== 1'b1 || AERIN_REQ !== 1'b0) begin
            fails++;
            $display("FAIL single_plus1: busy=%b req=%b want 1 0",
                     AERIN_CTRL_BUSY, AERIN_REQ);
        end
        @(negedge CLK);
        tests++;
        if (AERIN_REQ !== 1'b1 || AERIN_ADDR !== 12'h025) begin
            fails++;
            $display("FAIL single_plus2: req=%b addr=%h want 1 025",
                     AERIN_REQ, AERIN_ADDR);
        end
        wait_busy_low("single");
        tests++;
        if (SPIKE_CNT !== 3'd1 || AERIN_ACK !== 1'b0) begin
            fails++;
            $display("FAIL single_done: cnt=%0d ack=%b want 1 0",
                     SPIKE_CNT, AERIN_ACK);
        end
        tests++;
        if (req_count != r0 + 1) begin
            fails++;
            $display("FAIL single_reqs: got %0d want %0d",
                     req_count - r0, 1);
        end
    endtask

    task automatic test_held_found();
        int r0;
        r0 = req_count;
        @(negedge CLK);
        NEXT_INDEX       = 10'd5;
        FOUND_NEXT_INDEX = 1'b1;
        repeat (6) @(negedge CLK);
        FOUND_NEXT_INDEX = 1'b0;
        wait_busy_low("held");
        repeat (3) @(negedge CLK);
        tests++;
        if (req_count != r0 + 1 || addr_q[$] !== 12'h005) begin
            fails++;
            $display("FAIL held_once: reqs=%0d addr=%h want 1 005",
                     req_count - r0, addr_q[$]);
        end
        tests++;
        if (SPIKE_CNT !== 3'd2) begin
            fails++;
            $display("FAIL held_cnt: got %0d want 2", SPIKE_CNT);
        end
        // FOUND still high for one cycle after BUSY falls
        r0 = req_count;
        @(negedge CLK);
        NEXT_INDEX       = 10'd8;
        FOUND_NEXT_INDEX = 1'b1;
        @(negedge CLK);
        wait_busy_low("guard");
        @(negedge CLK);
        FOUND_NEXT_INDEX = 1'b0;
        repeat (4) @(negedge CLK);
        tests++;
        if (req_count != r0 + 1 || AERIN_CTRL_BUSY !== 1'b0) begin
            fails++;
            $display("FAIL guard_resend: reqs=%0d busy=%b want 1 0",
                     req_count - r0, AERIN_CTRL_BUSY);
        end
        tests++;
        if (SPIKE_CNT !== 3'd3) begin
            fails++;
            $display("FAIL guard_cnt: got %0d want 3", SPIKE_CNT);
        end
        pulse_new_image();
    endtask

    task automatic test_full_image();
        int s0;
        int q0;
        s0 = sent_count;
        q0 = addr_q.size();
        for (int i = 0; i < 7; i++) begin
            send_event(idx_tab[i], 1);
            tests++;
            if (SPIKE_CNT !== 3'(i + 1)) begin
                fails++;
                $display("FAIL image_cnt_%0d: got %0d want %0d",
                         i, SPIKE_CNT, i + 1);
            end
        end
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (addr_q[q0 + i] !== {2'b00, idx_tab[i]}) begin
                fails++;
                $display("FAIL image_order_%0d: got %h want %h",
                         i, addr_q[q0 + i], {2'b00, idx_tab[i]});
            end
        end
        @(negedge CLK);
        tests++;
        if (IMAGE_SENT !== 1'b1 || SPIKE_CNT !== 3'd0) begin
            fails++;
            $display("FAIL image_wrap: sent=%b cnt=%0d want 1 0",
                     IMAGE_SENT, SPIKE_CNT);
        end
        @(negedge CLK);
        tests++;
        if (IMAGE_SENT !== 1'b0 || sent_count != s0 + 1) begin
            fails++;
            $display("FAIL image_pulse: sent=%b pulses=%0d want 0 1",
                     IMAGE_SENT, sent_count - s0);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] c0;
        int         high;
        c0         = SPIKE_CNT;
        high       = 0;
        ack_manual = 1'b1;
        ack_man    = 1'b0;
        @(negedge CLK);
        NEXT_INDEX       = 10'd9;
        FOUND_NEXT_INDEX = 1'b1;
        @(negedge CLK);
        FOUND_NEXT_INDEX = 1'b0;
        @(negedge CLK);
        tests++;
        if (AERIN_REQ !== 1'b1) begin
            fails++;
            $display("FAIL to_req_up: got %b want 1", AERIN_REQ);
        end
        repeat (7) begin
            @(negedge CLK);
            if (AERIN_REQ === 1'b1) high++;
        end
        tests++;
        if (high != 7) begin
            fails++;
            $display("FAIL to_req_hold: got %0d want 7", high);
        end
        @(negedge CLK);
        tests++;
        if (AERIN_REQ !== 1'b0 || AERIN_CTRL_BUSY !== 1'b0) begin
            fails++;
            $display("FAIL to_drop: req=%b busy=%b want 0 0",
                     AERIN_REQ, AERIN_CTRL_BUSY);
        end
        tests++;
        if (ERR_TIMEOUT !== 1'b1 || SPIKE_CNT !== c0) begin
            fails++;
            $display("FAIL to_flag: err=%b cnt=%0d want 1 %0d",
                     ERR_TIMEOUT, SPIKE_CNT, c0);
        end
        ack_manual = 1'b0;
        send_event(10'd11, 1);
        tests++;
        if (SPIKE_CNT !== 3'(c0 + 1) || addr_q[$] !== 12'h00b) begin
            fails++;
            $display("FAIL to_next: cnt=%0d addr=%h want %0d 00b",
                     SPIKE_CNT, addr_q[$], c0 + 1);
        end
        tests++;
        if (ERR_TIMEOUT !== 1'b1) begin
            fails++;
            $display("FAIL to_sticky: got %b want 1", ERR_TIMEOUT);
        end
    endtask

    task automatic test_new_image_mid();
        send_event(10'd13, 1);
        send_event(10'd14, 1);
        tests++;
        if (SPIKE_CNT !== 3'd3) begin
            fails++;
            $display("FAIL mid_pre_cnt: got %0d want 3", SPIKE_CNT);
        end
        ack_manual = 1'b1;
        ack_man    = 1'b0;
        @(negedge CLK);
        NEXT_INDEX       = 10'd15;
        FOUND_NEXT_INDEX = 1'b1;
        @(negedge CLK);
        FOUND_NEXT_INDEX = 1'b0;
        wait_req(1'b1, "mid_up");
        ack_man = 1'b1;
        wait_req(1'b0, "mid_down");
        ack_man = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        tests++;
        if (AERIN_CTRL_BUSY !== 1'b1 || SPIKE_CNT !== 3'd3) begin
            fails++;
            $display("FAIL mid_ack_l: busy=%b cnt=%0d want 1 3",
                     AERIN_CTRL_BUSY, SPIKE_CNT);
        end
        NEW_IMAGE = 1'b1;
        @(negedge CLK);
        NEW_IMAGE = 1'b0;
        tests++;
        if (AERIN_CTRL_BUSY !== 1'b0 || AERIN_REQ !== 1'b0) begin
            fails++;
            $display("FAIL mid_complete: busy=%b req=%b want 0 0",
                     AERIN_CTRL_BUSY, AERIN_REQ);
        end
        tests++;
        if (SPIKE_CNT !== 3'd0 || addr_q[$] !== 12'h00f) begin
            fails++;
            $display("FAIL mid_clear: cnt=%0d addr=%h want 0 00f",
                     SPIKE_CNT, addr_q[$]);
        end
        ack_manual = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_held_found();
        test_full_image();
        test_timeout();
        test_new_image_mid();
        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t limit reached", $time);
        $fatal(1, "watchdog");
    end

endmodule
